// File: rtl/spi_read_data.sv
`default_nettype none
// ============================================================================
// Module   : spi_read_data
// Purpose  : SPI READ (opcode 0x03) master for an M25P16 serial flash.
//            Sends {0x03, addr[23:0]} MSB first, then clocks in `len` bytes
//            and presents each one on rd_data with a one-cycle rd_valid.
//            The SPI pins are shared with other stages through an external
//            mux. This block drives the bus only while busy is high.
// Ports    : sys_clk, sys_rst_n        - clock, async active-low reset
//            start, addr, len          - command request (sampled in IDLE)
//            spi_miso                  - flash serial data out
//            spi_sclk, spi_cs, spi_mosi - SPI mode 0 master outputs
//            rd_data, rd_valid         - received byte stream
//            busy, done                - command status
// Revision : 1.0 - initial release
// ============================================================================
module spi_read_data #(
  parameter int HALF_DIV = 2,  // sys_clk cycles per spi_sclk half-period (>= 1)
  parameter int CS_SETUP = 2,  // cycles spi_cs is low before shifting starts (>= 1)
  parameter int CS_HOLD  = 2,  // cycles after the last sclk fall before spi_cs rises (>= 1)
  parameter int LEN_W    = 9   // width of the byte-count input
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic             spi_miso,
  output logic             spi_sclk,
  output logic             spi_cs,
  output logic             spi_mosi,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_SETUP    = 3'd1;
  localparam logic [2:0] c_ST_SHIFT_TX = 3'd2;
  localparam logic [2:0] c_ST_SHIFT_RX = 3'd3;
  localparam logic [2:0] c_ST_HOLD     = 3'd4;
  localparam logic [2:0] c_ST_DONE     = 3'd5;

  localparam int c_DIV_W   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int c_CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(HALF_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_HOLD - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_END   = c_CNT_W'(CS_HOLD);
  localparam logic [7:0]         c_OP_READ    = 8'h03;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [c_DIV_W-1:0] r_div;     // position inside the current sclk half-period
  logic [c_CNT_W-1:0] r_cnt;     // SETUP / HOLD cycle counter
  logic [4:0]         r_bit;     // falling edges seen; [2:0] is the bit-in-byte during RX
  logic [LEN_W-1:0]   r_bytes;   // bytes still to be received
  logic [31:0]        r_tx_sr;   // command shift register, bit 31 drives spi_mosi
  logic [6:0]         r_rx_sr;   // first seven bits of the byte being received
  logic               r_sclk;
  logic               r_cs;
  logic [7:0]         r_rd_data;
  logic               r_rd_valid;

  // --------------------------------------------------------------------------
  // Decode helpers
  // --------------------------------------------------------------------------
  logic w_shifting;
  logic w_half_end;
  logic w_rise;
  logic w_fall;
  logic w_byte_end;
  logic w_tx_done;
  logic w_rx_done;
  logic w_accept;

  assign w_shifting = (r_state == c_ST_SHIFT_TX) || (r_state == c_ST_SHIFT_RX);
  assign w_half_end = w_shifting && (r_div == c_DIV_LAST);
  // r_sclk toggles at the end of each half, so the edge that ends a low half
  // is the rising edge and the edge that ends a high half is the falling edge.
  assign w_rise     = w_half_end && !r_sclk;
  assign w_fall     = w_half_end &&  r_sclk;
  assign w_byte_end = (r_bit[2:0] == 3'd7);
  assign w_tx_done  = w_fall && (r_bit == 5'd31);
  // r_bytes is decremented on the rising edge of the last bit, so it already
  // reads zero on the falling edge that closes the final byte.
  assign w_rx_done  = w_fall && w_byte_end && (r_bytes == '0);
  assign w_accept   = (r_state == c_ST_IDLE) && start && (len != '0);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        // A zero-length request skips the bus entirely and only reports done.
        if (start) begin
          w_state_nxt = (len != '0) ? c_ST_SETUP : c_ST_DONE;
        end
      end
      c_ST_SETUP: begin
        if (r_cnt == c_SETUP_LAST) begin
          w_state_nxt = c_ST_SHIFT_TX;
        end
      end
      c_ST_SHIFT_TX: begin
        if (w_tx_done) begin
          w_state_nxt = c_ST_SHIFT_RX;
        end
      end
      c_ST_SHIFT_RX: begin
        if (w_rx_done) begin
          w_state_nxt = c_ST_HOLD;
        end
      end
      c_ST_HOLD: begin
        // HOLD spans CS_HOLD cycles with spi_cs low plus one cycle with
        // spi_cs already high, so done follows the rise of spi_cs.
        if (r_cnt == c_HOLD_END) begin
          w_state_nxt = c_ST_DONE;
        end
      end
      c_ST_DONE: begin
        w_state_nxt = c_ST_IDLE;
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_ST_SETUP, c_ST_SHIFT_TX, c_ST_SHIFT_RX, c_ST_HOLD: busy = 1'b1;
      c_ST_DONE:                                           done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: sclk generation, shift registers, counters
  // The SPI pins come straight from flops so the shared bus never glitches.
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_div      <= '0;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_bytes    <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_sclk     <= 1'b0;
      r_cs       <= 1'b1;
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_tx_sr <= {c_OP_READ, addr};
            r_bytes <= len;
            r_cs    <= 1'b0;
            r_cnt   <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_sclk  <= 1'b0;
          end
        end

        c_ST_SETUP: begin
          r_div <= '0;
          if (r_cnt == c_SETUP_LAST) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        c_ST_SHIFT_TX, c_ST_SHIFT_RX: begin
          if (w_half_end) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
          end else begin
            r_div <= r_div + 1'b1;
          end

          // miso was launched by the flash on the previous falling edge and
          // is stable when sclk rises.
          if (w_rise && (r_state == c_ST_SHIFT_RX)) begin
            r_rx_sr <= {r_rx_sr[5:0], spi_miso};
            if (w_byte_end) begin
              r_rd_data  <= {r_rx_sr, spi_miso};
              r_rd_valid <= 1'b1;
              r_bytes    <= r_bytes - 1'b1;
            end
          end

          // mosi moves only on falling edges. Zeros shift in behind the
          // command, so mosi is already 0 for the whole receive phase.
          // r_bit wraps from 31 to 0 on the last command bit, which lines
          // it up as the bit-in-byte counter for RX.
          if (w_fall) begin
            r_bit <= r_bit + 1'b1;
            if (r_state == c_ST_SHIFT_TX) begin
              r_tx_sr <= {r_tx_sr[30:0], 1'b0};
            end
          end

          if (w_rx_done) begin
            r_cnt <= '0;
          end
        end

        c_ST_HOLD: begin
          if (r_cnt == c_HOLD_LAST) begin
            r_cs <= 1'b1;
          end
          if (r_cnt != c_HOLD_END) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        c_ST_DONE: begin
          r_cnt <= '0;
        end

        default: begin
          r_cs   <= 1'b1;
          r_sclk <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output assignments
  // --------------------------------------------------------------------------
  assign spi_sclk = r_sclk;
  assign spi_cs   = r_cs;
  assign spi_mosi = r_tx_sr[31];
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_read_data.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_read_data
// Purpose  : Self-checking bench for spi_read_data. A behavioural M25P16
//            model answers READ commands from a preloaded memory. Expected
//            bytes are queued when each command is issued, and a monitor pops
//            and compares them on every rd_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_read_data;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        start     = 1'b0;
  logic [23:0] addr      = '0;
  logic [8:0]  len       = '0;
  logic        spi_miso  = 1'b0;
  logic        spi_sclk;
  logic        spi_cs;
  logic        spi_mosi;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;

  always #10 sys_clk = ~sys_clk;

  spi_read_data #(
    .HALF_DIV (2),
    .CS_SETUP (2),
    .CS_HOLD  (2),
    .LEN_W    (9)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .addr      (addr),
    .len       (len),
    .spi_miso  (spi_miso),
    .spi_sclk  (spi_sclk),
    .spi_cs    (spi_cs),
    .spi_mosi  (spi_mosi),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .done      (done)
  );

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  int          busy_cycles   = 0;
  int          cs_low_cycles = 0;
  int          done_cnt      = 0;
  int          valid_cnt     = 0;
  int          sclk_rises    = 0;
  logic [2:0]  cs_hist       = 3'b111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Flash model: erased (0xFF) except for the preloaded locations
  // --------------------------------------------------------------------------
  logic [7:0]  mem [int unsigned];
  int unsigned f_rises = 0;
  logic [31:0] f_cmd   = '0;

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    int unsigned key;
    key = {8'h00, a};
    if (mem.exists(key)) return mem[key];
    return 8'hFF;
  endfunction

  always @(negedge spi_cs) begin
    f_rises = 0;
    f_cmd   = '0;
  end

  always @(posedge spi_sclk) begin
    if (f_rises < 32) f_cmd = {f_cmd[30:0], spi_mosi};
    f_rises++;
    sclk_rises++;
  end

  always @(negedge spi_sclk) begin
    int unsigned k;
    logic [7:0]  b;
    if (!spi_cs && f_rises >= 32) begin
      k = f_rises - 32;
      b = mem_rd(f_cmd[23:0] + 24'(k / 8));
      spi_miso = b[7 - (k % 8)];
    end
  end

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  always @(negedge sys_clk) begin
    cs_hist = {cs_hist[1:0], spi_cs};
    if (busy === 1'b1)    busy_cycles++;
    if (spi_cs === 1'b0)  cs_low_cycles++;
    if (done === 1'b1)    done_cnt++;
    if (rd_valid === 1'b1) begin
      valid_cnt++;
      if (exp_q.size() == 0) chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
      else                   chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  end

  // --------------------------------------------------------------------------
  // One READ command; expected bytes must already be queued.
  // inject_at >= 0 raises a second start that many cycles into the command.
  // --------------------------------------------------------------------------
  task automatic run_read(input logic [23:0] a, input logic [8:0] n, input int exp_busy,
                          input int inject_at, input bit start_in_done);
    int cyc;
    int exp_valid;
    exp_valid = exp_q.size();
    tick();
    busy_cycles = 0; cs_low_cycles = 0; done_cnt = 0; valid_cnt = 0; sclk_rises = 0;
    addr = a; len = n; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      if (cyc == inject_at) begin
        addr = 24'hABCDEF; len = 9'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_cycles", 32'(busy_cycles), 32'(exp_busy));
    chk("sclk_rises", 32'(sclk_rises), (n == 0) ? 32'd0 : 32'(8 * (4 + n)));
    chk("rd_valid_count", 32'(valid_cnt), 32'(exp_valid));
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    if (n != 0) begin
      chk("cmd_word", f_cmd, {8'h03, a});
      chk("cs_low_cycles", 32'(cs_low_cycles), 32'(exp_busy - 1));
      chk("cs_rise_to_done", 32'(cs_hist), 32'b011);
    end else begin
      chk("len0_done_latency", 32'(cyc), 32'd0);
      chk("len0_cs_low", 32'(cs_low_cycles), 32'd0);
    end
    if (start_in_done) begin
      addr = 24'h000000; len = 9'd1; start = 1'b1;
    end
    tick();
    start = 1'b0;
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cs", 32'(spi_cs), 32'd1);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[32'h0000_1234] = 8'hA5;
    mem[32'h00FF_FFFF] = 8'h5A;

    // Asynchronous reset before any clock edge
    #2 sys_rst_n = 1'b0;
    #3;
    chk("rst_cs",       32'(spi_cs),   32'd1);
    chk("rst_sclk",     32'(spi_sclk), 32'd0);
    chk("rst_mosi",     32'(spi_mosi), 32'd0);
    chk("rst_rd_data",  32'(rd_data),  32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    tick(); tick();
    sys_rst_n = 1'b1;
    tick();

    // Frame check: 40 rising edges, one byte
    exp_q.push_back(8'hA5);
    run_read(24'h001234, 9'd1, 165, -1, 1'b0);

    // Readback of programmed data
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    run_read(24'h000000, 9'd4, 261, -1, 1'b0);

    // Erased sector
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    run_read(24'h010000, 9'd3, 229, -1, 1'b0);

    // Zero-length request
    run_read(24'h000100, 9'd0, 0, -1, 1'b0);

    // Start while busy, and a start during the done cycle
    exp_q.push_back(8'h10); exp_q.push_back(8'h11);
    run_read(24'h000010, 9'd2, 197, 50, 1'b1);

    // Address wrap is the flash's business; the command word is passed through
    exp_q.push_back(8'h5A); exp_q.push_back(8'h00);
    run_read(24'hFFFFFF, 9'd2, 197, -1, 1'b0);

    // Reset during the second data byte
    exp_q.push_back(8'h00);
    tick();
    addr = 24'h000000; len = 9'd3; start = 1'b1;
    tick();
    start = 1'b0;
    valid_cnt = 0;
    cyc = 0;
    while (valid_cnt < 1 && cyc < 1000) begin
      tick();
      cyc++;
    end
    chk("first_byte_before_reset", 32'(valid_cnt), 32'd1);
    repeat (20) tick();
    #3 sys_rst_n = 1'b0;
    #1;
    chk("midrst_cs",       32'(spi_cs),   32'd1);
    chk("midrst_sclk",     32'(spi_sclk), 32'd0);
    chk("midrst_busy",     32'(busy),     32'd0);
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    valid_cnt = 0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    repeat (100) tick();
    chk("no_valid_after_reset", 32'(valid_cnt), 32'd0);
    chk("midrst_q_empty", 32'(exp_q.size()), 32'd0);

    // Normal frame after reset release
    exp_q.push_back(8'h04); exp_q.push_back(8'h05);
    run_read(24'h000004, 9'd2, 197, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
